// File: rtl/mux_scan_ctrl.sv
// Scans enabled 4:1 mux channels (SETTLE+2 cycles each), packs y samples into a frame held until frame_ready.
// Optional frame_parity output when MUX_SCAN_PARITY_EN is defined; start is ignored while busy.
module mux_scan_ctrl #(
  parameter int DATA_W = 1,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          ch_mask,
  output logic                s1,
  output logic                s2,
  input  logic [DATA_W-1:0]   y,
  output logic [4*DATA_W-1:0] frame_data,
  output logic [3:0]          frame_mask,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                busy,
  output logic                done
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                frame_parity
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EMIT
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t state, state_nxt;
  logic [1:0] cur_ch;
  logic [3:0] settle_cnt;
  logic [2:0] first_ch;
  logic [2:0] next_ch;
  logic [4*DATA_W-1:0] frame_data_nxt;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] first_from(input logic [3:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, i[1:0]};
    end
    return r;
  endfunction

  assign first_ch = first_from(ch_mask, 0);
  assign next_ch  = first_from(frame_mask, int'(cur_ch) + 1);

  always_comb begin
    frame_data_nxt = frame_data;
    frame_data_nxt[int'(cur_ch)*DATA_W +: DATA_W] = y;
  end

  assign busy        = (state != ST_IDLE);
  assign frame_valid = (state == ST_EMIT);
  assign done        = (state == ST_EMIT) && frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start && (ch_mask != 4'd0)) state_nxt = ST_SELECT;
      ST_SELECT: state_nxt = (SETTLE_CNT == 4'd0) ? ST_SAMPLE : ST_SETTLE;
      ST_SETTLE: if (settle_cnt <= 4'd1) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = next_ch[2] ? ST_SELECT : ST_EMIT;
      ST_EMIT:   if (frame_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      cur_ch       <= 2'd0;
      settle_cnt   <= 4'd0;
      frame_data   <= '0;
      frame_mask   <= 4'd0;
`ifdef MUX_SCAN_PARITY_EN
      frame_parity <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (ch_mask != 4'd0)) begin
            frame_mask   <= ch_mask;
            frame_data   <= '0;
            cur_ch       <= first_ch[1:0];
`ifdef MUX_SCAN_PARITY_EN
            frame_parity <= 1'b0;
`endif
          end
        end
        ST_SELECT: begin
          {s1, s2}   <= cur_ch;
          settle_cnt <= SETTLE_CNT;
        end
        ST_SETTLE: settle_cnt <= settle_cnt - 4'd1;
        ST_SAMPLE: begin
          frame_data   <= frame_data_nxt;
`ifdef MUX_SCAN_PARITY_EN
          frame_parity <= ^frame_data_nxt;
`endif
          if (next_ch[2]) cur_ch <= next_ch[1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl (DATA_W=1, SETTLE=1) with a behavioural 4:1 mux on y.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] ch_mask;
  logic       s1, s2;
  logic [0:0] y;
  logic [3:0] frame_data;
  logic [3:0] frame_mask;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  logic       done;
`ifdef MUX_SCAN_PARITY_EN
  logic       frame_parity;
`endif

  logic [3:0] dvec;  // bit i = mux data for channel i (a=0 .. d=3)
  int n_pass;
  int n_total;

  mux_scan_ctrl #(.DATA_W(1), .SETTLE(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ch_mask     (ch_mask),
    .s1          (s1),
    .s2          (s2),
    .y           (y),
    .frame_data  (frame_data),
    .frame_mask  (frame_mask),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .done        (done)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .frame_parity(frame_parity)
`endif
  );

  assign y = dvec[{s1, s2}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start lands on the next rising edge (edge k); returns just after edge k.
  task automatic do_start(input logic [3:0] m);
    @(negedge clk);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; ch_mask = 4'h0; frame_ready = 1'b1; dvec = 4'h0;
    #3;
    if ({s1, s2, frame_valid, busy, done} !== 5'b0) $display("FAIL reset_ctrl got=%b exp=%b", {s1, s2, frame_valid, busy, done}, 5'b0);
    else n_pass++;
    n_total++;
    if ({frame_data, frame_mask} !== 8'h00) $display("FAIL reset_frame got=%h exp=%h", {frame_data, frame_mask}, 8'h00);
    else n_pass++;
    n_total++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    if (busy !== 1'b0) $display("FAIL reset_idle busy got=%b exp=0", busy);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_full_scan;
    dvec = 4'b0101; frame_ready = 1'b1;
    do_start(4'hF);
    ch_mask = 4'h0;  // must not affect the running scan
    repeat (11) @(negedge clk);
    if ({frame_valid, busy} !== 2'b01) $display("FAIL full_pre_valid got=%b exp=01", {frame_valid, busy});
    else n_pass++;
    n_total++;
    @(negedge clk);
    if ({frame_valid, done} !== 2'b11) $display("FAIL full_valid_done got=%b exp=11", {frame_valid, done});
    else n_pass++;
    n_total++;
    if (frame_data !== 4'b0101) $display("FAIL full_data got=%b exp=0101", frame_data);
    else n_pass++;
    n_total++;
    if (frame_mask !== 4'hF) $display("FAIL full_mask got=%h exp=f", frame_mask);
    else n_pass++;
    n_total++;
`ifdef MUX_SCAN_PARITY_EN
    if (frame_parity !== 1'b0) $display("FAIL full_parity got=%b exp=0", frame_parity);
    else n_pass++;
    n_total++;
`endif
    @(negedge clk);
    if ({frame_valid, done, busy} !== 3'b000) $display("FAIL full_after got=%b exp=000", {frame_valid, done, busy});
    else n_pass++;
    n_total++;
    if ({s1, s2} !== 2'b11) $display("FAIL full_sel_hold got=%b exp=11", {s1, s2});
    else n_pass++;
    n_total++;
  endtask

  task automatic test_sparse;
    dvec = 4'hF; frame_ready = 1'b1;
    do_start(4'b1010);
    @(negedge clk);
    if ({s1, s2} !== 2'b01) $display("FAIL sparse_sel1 got=%b exp=01", {s1, s2});
    else n_pass++;
    n_total++;
    repeat (3) @(negedge clk);
    if ({s1, s2} !== 2'b11) $display("FAIL sparse_sel2 got=%b exp=11", {s1, s2});
    else n_pass++;
    n_total++;
    @(negedge clk);
    if (frame_valid !== 1'b0) $display("FAIL sparse_early got=%b exp=0", frame_valid);
    else n_pass++;
    n_total++;
    @(negedge clk);
    if ({frame_valid, frame_data, frame_mask} !== 9'b1_1010_1010)
      $display("FAIL sparse_frame got=%b exp=%b", {frame_valid, frame_data, frame_mask}, 9'b1_1010_1010);
    else n_pass++;
    n_total++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    dvec = 4'b0011; frame_ready = 1'b0;
    do_start(4'hF);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if ({frame_valid, done, frame_data} !== 6'b10_0011)
        $display("FAIL bp_hold cyc=%0d got=%b exp=%b", i, {frame_valid, done, frame_data}, 6'b10_0011);
      else n_pass++;
      n_total++;
      dvec  = ~dvec;
      start = (i == 2);
      @(negedge clk);
    end
    start = 1'b1;  // also ignored on the handshake cycle
    frame_ready = 1'b1;
    #1;
    if ({frame_valid, done, frame_data} !== 6'b11_0011)
      $display("FAIL bp_done got=%b exp=%b", {frame_valid, done, frame_data}, 6'b11_0011);
    else n_pass++;
    n_total++;
    @(negedge clk);
    start = 1'b0;
    if ({frame_valid, done, busy} !== 3'b000) $display("FAIL bp_after got=%b exp=000", {frame_valid, done, busy});
    else n_pass++;
    n_total++;
    repeat (15) @(negedge clk);
    if ({frame_valid, busy} !== 2'b00) $display("FAIL bp_no_rescan got=%b exp=00", {frame_valid, busy});
    else n_pass++;
    n_total++;
  endtask

  task automatic test_abort;
    dvec = 4'b0110; frame_ready = 1'b1;
    do_start(4'hF);
    repeat (7) @(negedge clk);  // channel c is settling
    if ({s1, s2, busy} !== 3'b101) $display("FAIL abort_pre got=%b exp=101", {s1, s2, busy});
    else n_pass++;
    n_total++;
    rst_n = 1'b0;
    #1;
    if ({s1, s2, frame_valid, busy, done, frame_data, frame_mask} !== 13'b0)
      $display("FAIL abort_zero got=%b exp=0", {s1, s2, frame_valid, busy, done, frame_data, frame_mask});
    else n_pass++;
    n_total++;
    @(negedge clk);
    rst_n = 1'b1;
    dvec = 4'b1001;
    do_start(4'hF);
    repeat (12) @(negedge clk);
    if ({frame_valid, frame_data} !== 5'b1_1001) $display("FAIL abort_clean got=%b exp=%b", {frame_valid, frame_data}, 5'b1_1001);
    else n_pass++;
    n_total++;
    @(negedge clk);
  endtask

  task automatic test_guard;
    do_start(4'h0);
    repeat (4) @(negedge clk);
    if ({busy, frame_valid} !== 2'b00) $display("FAIL guard_busy got=%b exp=00", {busy, frame_valid});
    else n_pass++;
    n_total++;
  endtask

`ifdef MUX_SCAN_PARITY_EN
  task automatic test_parity;
    dvec = 4'b0111; frame_ready = 1'b1;
    do_start(4'hF);
    repeat (12) @(negedge clk);
    if ({frame_valid, frame_data, frame_parity} !== 6'b1_0111_1)
      $display("FAIL parity_odd got=%b exp=%b", {frame_valid, frame_data, frame_parity}, 6'b1_0111_1);
    else n_pass++;
    n_total++;
    @(negedge clk);
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_full_scan();
    test_sparse();
    test_backpressure();
    test_abort();
    test_guard();
`ifdef MUX_SCAN_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
